// File: rtl/bit_serialiser.sv
// bit_serialiser
//   Parallel-to-serial front end for the bit-pattern recognition datapath.
//   Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
//   one bit per clock. A one-entry holding buffer lets consecutive words
//   stream with no idle cycles between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//
// Ports
//   clock       system clock, rising edge
//   nreset      asynchronous active-low reset
//   din         parallel word to serialise
//   din_valid   din holds a word to transfer
//   din_ready   block can accept a word this cycle
//   sout        serial bit stream, 0 when idle
//   sout_valid  sout carries a data bit this cycle
//   last        sout carries the final bit of a word
//   busy        a word is being shifted or is held in the buffer
module bit_serialiser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hbuf;
    logic [CW-1:0]    cnt;
    logic             hfull;

    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] sreg_next;

    always_comb begin
        // Shifter can take a new word at this edge: empty, or on its last bit.
        free = (state == IDLE) || (cnt == CNT_MAX);
        xfer = din_valid && !hfull;
        if (MSB_FIRST) begin
            sreg_next = {sreg[WIDTH-2:0], 1'b0};
        end else begin
            sreg_next = {1'b0, sreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            hbuf  <= '0;
            hfull <= 1'b0;
        end else begin
            if (free && hfull) begin
                // Buffered word has priority over any new transfer.
                sreg  <= hbuf;
                cnt   <= '0;
                state <= SHIFT;
                hfull <= xfer;
                if (xfer) begin
                    hbuf <= din;
                end
            end else if (free && xfer) begin
                // Bypass: word goes straight into the shifter.
                sreg  <= din;
                cnt   <= '0;
                state <= SHIFT;
            end else begin
                if (xfer) begin
                    hbuf  <= din;
                    hfull <= 1'b1;
                end
                if (free) begin
                    state <= IDLE;
                    cnt   <= '0;
                    sreg  <= '0;
                end else begin
                    cnt  <= cnt + 1'b1;
                    sreg <= sreg_next;
                end
            end
        end
    end

    // Outputs are plain decodes of registered state.
    assign din_ready  = !hfull;
    assign sout_valid = (state == SHIFT);
    assign sout       = (state == SHIFT) && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign last       = (state == SHIFT) && (cnt == CNT_MAX);
    assign busy       = (state == SHIFT) || hfull;

endmodule

// File: tb/tb_bit_serialiser.sv
module tb_bit_serialiser;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    logic         clock = 1'b0;
    logic         nreset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic din_ready_m, sout_m, sout_valid_m, last_m, busy_m;
    logic din_ready_l, sout_l, sout_valid_l, last_l, busy_l;

    exp_t q_m[$];
    exp_t q_l[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    bit_serialiser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .nreset(nreset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_m), .sout(sout_m), .sout_valid(sout_valid_m),
        .last(last_m), .busy(busy_m)
    );

    bit_serialiser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .nreset(nreset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
        .last(last_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted word becomes W queued bits in send order;
    // the queue holds everything accepted but not yet shown on sout.
    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q_m.push_back('{b: w[W-1-i], l: (i == W-1)});
            q_l.push_back('{b: w[i],     l: (i == W-1)});
        end
    endfunction

    // Monitor: pending-bit count alone determines sout_valid, busy and
    // din_ready (more than one word pending means the buffer is full).
    always @(negedge clock) begin
        exp_t e;
        int   n;
        n = q_m.size();
        chk("msb_sout_valid", sout_valid_m, n > 0);
        chk("msb_busy", busy_m, n > 0);
        chk("msb_din_ready", din_ready_m, n <= W);
        if (n > 0) begin
            e = q_m.pop_front();
            chk("msb_sout", sout_m, e.b);
            chk("msb_last", last_m, e.l);
        end else begin
            chk("msb_sout_idle", sout_m, 1'b0);
            chk("msb_last_idle", last_m, 1'b0);
        end
        n = q_l.size();
        chk("lsb_sout_valid", sout_valid_l, n > 0);
        chk("lsb_busy", busy_l, n > 0);
        chk("lsb_din_ready", din_ready_l, n <= W);
        if (n > 0) begin
            e = q_l.pop_front();
            chk("lsb_sout", sout_l, e.b);
            chk("lsb_last", last_l, e.l);
        end else begin
            chk("lsb_sout_idle", sout_l, 1'b0);
            chk("lsb_last_idle", last_l, 1'b0);
        end
    end

    // Offer a word and hold it until accepted (bounded wait).
    task automatic send(input logic [W-1:0] w);
        bit acc;
        acc       = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            #1;
            if (din_ready_m) begin
                push_word(w);
                acc = 1'b1;
            end
            @(posedge clock);
            #1;
            if (acc) break;
        end
        din_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: word %h accepted %b expected 1", w, acc);
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One cycle of unconstrained traffic; din changes freely while stalled.
    task automatic rand_cycle();
        din_valid = ($urandom_range(0, 3) != 0);
        din       = W'($urandom);
        @(negedge clock);
        #1;
        if (din_valid && din_ready_m) push_word(din);
        @(posedge clock);
        #1;
    endtask

    initial begin
        nreset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;

        idle(20);

        send(8'hA0);
        idle(10);

        send(8'hFF);
        send(8'h00);
        send(8'h5A);
        idle(30);

        send(8'h01);
        idle(10);

        // Pulse din_valid while the buffer is full.
        send(8'h11);
        send(8'h22);
        din       = 8'hEE;
        din_valid = 1'b1;
        @(negedge clock);
        #1;
        chk("pulse_ready_low", din_ready_m, 1'b0);
        if (din_ready_m) push_word(din);
        @(posedge clock);
        #1;
        din_valid = 1'b0;
        idle(25);

        // Reset during the third bit of C3 with 3C buffered.
        send(8'hC3);
        send(8'h3C);
        @(posedge clock);
        #1;
        @(negedge clock);
        #1;
        nreset = 1'b0;
        q_m.delete();
        q_l.delete();
        #1;
        chk("rst_msb_sout", sout_m, 1'b0);
        chk("rst_msb_sout_valid", sout_valid_m, 1'b0);
        chk("rst_msb_last", last_m, 1'b0);
        chk("rst_msb_busy", busy_m, 1'b0);
        chk("rst_msb_din_ready", din_ready_m, 1'b1);
        chk("rst_lsb_sout", sout_l, 1'b0);
        chk("rst_lsb_sout_valid", sout_valid_l, 1'b0);
        chk("rst_lsb_last", last_l, 1'b0);
        chk("rst_lsb_busy", busy_l, 1'b0);
        chk("rst_lsb_din_ready", din_ready_l, 1'b1);
        @(posedge clock);
        #1;
        nreset = 1'b1;
        idle(15);

        repeat (400) rand_cycle();
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serialiser.md
# bit_serialiser

Parallel-to-serial front end for the bit-pattern recognition datapath. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line. That line drives the recognition state machine's serial input directly. A one-entry holding buffer lets consecutive words stream with no idle cycles between them.

## Interface
- WIDTH, 8, word width in bits; must be ≥ 2
- MSB_FIRST, 1, 1 = send din[WIDTH-1] first; 0 = send din[0] first
- clock  input  1  system clock, all state updates on rising edge
- nreset  input  1  asynchronous, active-low reset
- din  input  WIDTH  parallel word to serialise
- din_valid  input  1  din holds a word to transfer
- din_ready  output  1  block can accept a word this cycle
- sout  output  1  serial bit stream; 0 when idle
- sout_valid  output  1  sout carries a data bit this cycle
- last  output  1  sout carries the final bit of a word
- busy  output  1  a word is being shifted or is held in the buffer

## Operation
- Storage:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, width $clog2(WIDTH)
  - holding buffer hbuf[WIDTH-1:0] with flag hfull
- State machine, two states:
  - IDLE: shifter empty.
  - SHIFT: sreg holds a word; cnt is the index of the bit currently on sout.
- Transfer: occurs at a rising edge when din_valid && din_ready.
- din_ready = ~hfull. Registered only; no combinational path from din_valid.
- Load sources at each edge, in priority order:
  - If shifter is free (IDLE, or SHIFT with cnt == WIDTH-1) and hfull: load sreg ← hbuf, cnt ← 0, enter/stay SHIFT, clear hfull. A transfer at the same edge writes hbuf and sets hfull.
  - Else if shifter is free and a transfer occurs (bypass): load sreg ← din, cnt ← 0, enter/stay SHIFT; hfull stays 0.
  - Else if a transfer occurs: hbuf ← din, hfull ← 1.
- Shifter free with no word available: go to IDLE.
- SHIFT with cnt < WIDTH-1: cnt ← cnt+1; sreg shifts left (MSB_FIRST=1) or right (MSB_FIRST=0).
- Outputs:
  - sout = sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0) in SHIFT; 0 in IDLE.
  - sout_valid = (state == SHIFT).
  - last = (state == SHIFT) && (cnt == WIDTH-1).
  - busy = (state == SHIFT) || hfull.
- Sending 0 when idle keeps the downstream recogniser from seeing spurious 1s.
- Reset (asynchronous, at any time, including mid-word):
  - state ← IDLE, cnt ← 0, sreg ← 0, hbuf ← 0, hfull ← 0.
  - Any partially sent word and any buffered word are discarded.
  - Reset values: sout 0, sout_valid 0, last 0, busy 0, din_ready 1.
- din is ignored when din_valid = 0 or din_ready = 0. Upstream must hold din/din_valid until accepted.

## Timing
- Latency, idle block: word accepted at edge k drives its first bit after edge k. Its final bit and last appear after edge k+WIDTH-1.
- Throughput: one bit per clock.
- Gapless streaming: if the buffer is filled any time before the final-bit edge, the next word's first bit follows the previous word's final bit with no gap.
- A second word offered at edge k+1 is accepted. A third word stalls (din_ready = 0) until the edge that moves hbuf into sreg. din_ready returns high in the following cycle.
- All outputs are registered state or simple decodes of it; there is no input-to-output combinational path.

## Test plan
- Reset then idle, din_valid = 0 for 20 cycles: sout = 0, sout_valid = 0, busy = 0, din_ready = 1 throughout.
- WIDTH=8, MSB_FIRST=1, din = 8'hA0 accepted at edge 0: sout = 1,0,1,0,0,0,0,0 after edges 0..7; last high only after edge 7; IDLE after edge 8. A chained recogniser pulses outp once, during the cycle following edge 2.
- Back-to-back: 8'hFF at edge 0, 8'h00 at edge 1, 8'h5A offered from edge 2:
  - din_ready low from after edge 1 through edge 8, so 8'h5A is accepted at edge 9.
  - sout runs 8 ones then 8 zeros then 0,1,0,1,1,0,1,0 with no gap.
  - sout_valid stays high for 24 cycles.
- MSB_FIRST=0, din = 8'h01: sout = 1,0,0,0,0,0,0,0.
- Reset asserted mid-word, after 3 bits of 8'hC3 with 8'h3C buffered: all outputs go to reset values immediately. After release, nothing further is sent until a new word is accepted.
- din_valid pulsed while din_ready = 0: the word is not captured and the serial output is unaffected.
